// File: rtl/tvp_config_sequencer.sv
// tvp_config_sequencer: walks a register table and writes each entry to the TVP decoder over I2C
module tvp_config_sequencer #(
  parameter logic [6:0] DEV_ADDR       = 7'h5C,
  parameter int         NUM_ENTRIES    = 64,
  parameter int         STARTUP_CYCLES = 20000,
  parameter int         GAP_CYCLES     = 100,
  parameter int         DELAY_UNIT     = 1000,
  parameter int         MAX_RETRY      = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  output logic [7:0]  TBL_IDX,
  input  logic [15:0] TBL_ENTRY,
  output logic        I2C_REQ,
  output logic [6:0]  I2C_DEV,
  output logic [7:0]  I2C_REG,
  output logic [7:0]  I2C_DATA,
  input  logic        I2C_DONE,
  input  logic        I2C_NACK,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [7:0]  ERR_IDX
);
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PWRWAIT  = 4'd1;
  localparam logic [3:0] S_FETCH    = 4'd2;
  localparam logic [3:0] S_DECODE   = 4'd3;
  localparam logic [3:0] S_ISSUE    = 4'd4;
  localparam logic [3:0] S_GAP      = 4'd5;
  localparam logic [3:0] S_DELAY    = 4'd6;
  localparam logic [3:0] S_COMPLETE = 4'd7;
  localparam logic [3:0] S_FAIL     = 4'd8;
  localparam int W1   = STARTUP_CYCLES > GAP_CYCLES ? STARTUP_CYCLES : GAP_CYCLES;
  localparam int WMAX = W1 > 255 * DELAY_UNIT ? W1 : 255 * DELAY_UNIT;
  localparam int CW   = $clog2(WMAX + 1);
  localparam logic [7:0] LAST = 8'(NUM_ENTRIES - 1);
  localparam logic [7:0] MR   = 8'(MAX_RETRY);
  logic [3:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] dly;
  logic [7:0]    tries;
  logic          again;
  logic [3:0]    adv_state;
  logic [7:0]    adv_idx;
  // status outputs, delay length and where the walk goes after finishing an entry
  always_comb begin
    adv_state = TBL_IDX == LAST ? S_COMPLETE : S_FETCH;
    adv_idx = TBL_IDX == LAST ? TBL_IDX : TBL_IDX + 8'd1;
    dly = CW'(TBL_ENTRY[7:0]) * CW'(DELAY_UNIT);
    I2C_REQ = state == S_ISSUE;
    I2C_DEV = DEV_ADDR;
    BUSY = !(state == S_IDLE || state == S_COMPLETE || state == S_FAIL);
    DONE = state == S_COMPLETE;
    ERROR = state == S_FAIL;
  end
  // sequencer: one shared down-counter times power-up wait, inter-write gap and table delays
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      TBL_IDX <= '0;
      I2C_REG <= '0;
      I2C_DATA <= '0;
      ERR_IDX <= '0;
      cnt <= '0;
      tries <= '0;
      again <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_COMPLETE, S_FAIL:
          if (START) begin
            state <= S_PWRWAIT;
            TBL_IDX <= '0;
            ERR_IDX <= '0;
            cnt <= CW'(STARTUP_CYCLES - 1);
          end
        S_PWRWAIT:
          if (cnt == '0) state <= S_FETCH;
          else cnt <= cnt - CW'(1);
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          I2C_REG <= TBL_ENTRY[15:8];
          I2C_DATA <= TBL_ENTRY[7:0];
          tries <= '0;
          if (TBL_ENTRY[15:8] != 8'hFF) state <= S_ISSUE;
          else if (TBL_ENTRY[7:0] == 8'd0) begin
            state <= adv_state;
            TBL_IDX <= adv_idx;
          end else begin
            state <= S_DELAY;
            cnt <= dly - CW'(1);
          end
        end
        S_ISSUE:
          if (I2C_DONE) begin
            if (!I2C_NACK || tries != MR) begin
              state <= S_GAP;
              cnt <= CW'(GAP_CYCLES - 1);
              again <= I2C_NACK;
              tries <= tries + {7'd0, I2C_NACK};
            end else begin
              state <= S_FAIL;
              ERR_IDX <= TBL_IDX;
            end
          end
        S_GAP:
          if (cnt != '0) cnt <= cnt - CW'(1);
          else if (again) state <= S_ISSUE;
          else begin
            state <= adv_state;
            TBL_IDX <= adv_idx;
          end
        S_DELAY:
          if (cnt != '0) cnt <= cnt - CW'(1);
          else begin
            state <= adv_state;
            TBL_IDX <= adv_idx;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tvp_config_sequencer.sv
// tb_tvp_config_sequencer: timeline model of the configuration walk, checked against the DUT every cycle
module tb_tvp_config_sequencer;
  localparam int N = 3, SU = 10, G = 4, DU = 8, MR = 3;
  logic CLK = 0, RESET = 1, START = 0, I2C_DONE = 0, I2C_NACK = 0;
  logic [15:0] TBL_ENTRY = '0;
  logic [7:0] TBL_IDX, I2C_REG, I2C_DATA, ERR_IDX;
  logic [6:0] I2C_DEV;
  logic I2C_REQ, BUSY, DONE, ERROR;
  logic [15:0] tbl [N];
  int nk [N];
  int total = 0, bad = 0, cyc = 0, t_start = 0, lat_fix = -1;
  logic chk_en = 0, noise = 0, prev_req = 0;
  logic e_req = 0, e_busy = 0, e_done = 0, e_err = 0;
  logic [7:0] e_idx = 0, e_reg = 0, e_data = 0, e_eidx = 0;
  logic [15:0] reqs [$];
  int rises [$];
  int falls [$];

  tvp_config_sequencer #(.DEV_ADDR(7'h5C), .NUM_ENTRIES(N), .STARTUP_CYCLES(SU),
    .GAP_CYCLES(G), .DELAY_UNIT(DU), .MAX_RETRY(MR)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .TBL_IDX(TBL_IDX), .TBL_ENTRY(TBL_ENTRY),
    .I2C_REQ(I2C_REQ), .I2C_DEV(I2C_DEV), .I2C_REG(I2C_REG), .I2C_DATA(I2C_DATA),
    .I2C_DONE(I2C_DONE), .I2C_NACK(I2C_NACK), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
    .ERR_IDX(ERR_IDX));

  always #5 CLK = ~CLK;

  // synchronous table ROM: entry valid one cycle after the index changes
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    TBL_ENTRY <= TBL_IDX < 8'(N) ? tbl[TBL_IDX[1:0]] : 16'h0;
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h at cycle %0d", nm, a, e, cyc);
    end
  endtask

  // request log used by the timing checks
  always @(negedge CLK) begin
    if (I2C_REQ && !prev_req) begin
      reqs.push_back({I2C_REG, I2C_DATA});
      rises.push_back(cyc);
    end
    if (!I2C_REQ && prev_req) falls.push_back(cyc);
    prev_req = I2C_REQ;
  end

  // every-cycle comparison against the model expectations
  always @(negedge CLK) if (chk_en) begin
    chk("req", I2C_REQ, e_req);
    chk("busy", BUSY, e_busy);
    chk("done", DONE, e_done);
    chk("error", ERROR, e_err);
    chk("idx", TBL_IDX, e_idx);
    chk("dev", I2C_DEV, 7'h5C);
    if (e_req) begin
      chk("reg", I2C_REG, e_reg);
      chk("data", I2C_DATA, e_data);
    end
    if (e_err) chk("err_idx", ERR_IDX, e_eidx);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_n(input int n, input bit nz);
    for (int k = 0; k < n; k++) begin
      if (nz && noise) begin
        I2C_DONE = $urandom_range(0, 3) == 0;
        I2C_NACK = 1'($urandom_range(0, 1));
        START = $urandom_range(0, 7) == 0;
      end
      step();
    end
    I2C_DONE = 0;
    I2C_NACK = 0;
    START = 0;
  endtask

  task automatic advance(inout int i, output bit fin);
    fin = i == N - 1;
    if (fin) begin
      e_busy = 0;
      e_done = 1;
    end else begin
      i++;
      e_idx = 8'(i);
    end
  endtask

  task automatic run(input int rst_at);
    int i = 0;
    int lat;
    bit fin = 0;
    bit acked;
    reqs.delete();
    rises.delete();
    falls.delete();
    START = 1;
    step();
    START = 0;
    t_start = cyc;
    e_busy = 1; e_done = 0; e_err = 0; e_idx = 0;
    wait_n(SU, 1);
    while (!fin) begin
      step();
      step();
      if (tbl[i][15:8] == 8'hFF) begin
        wait_n(int'(tbl[i][7:0]) * DU, 0);
        advance(i, fin);
      end else begin
        e_reg = tbl[i][15:8];
        e_data = tbl[i][7:0];
        acked = 0;
        for (int a = 0; !acked; a++) begin
          e_req = 1;
          if (i == rst_at) begin
            step();
            RESET = 1;
            step();
            RESET = 0;
            e_req = 0; e_busy = 0; e_done = 0; e_err = 0; e_idx = 0;
            return;
          end
          lat = lat_fix >= 0 ? lat_fix : int'($urandom_range(0, 6));
          repeat (lat) step();
          I2C_DONE = 1;
          I2C_NACK = a < nk[i];
          step();
          I2C_DONE = 0;
          I2C_NACK = 0;
          e_req = 0;
          if (a < nk[i] && a == MR) begin
            e_busy = 0;
            e_err = 1;
            e_eidx = 8'(i);
            return;
          end
          wait_n(G, 1);
          acked = a >= nk[i];
        end
        advance(i, fin);
      end
    end
  endtask

  function automatic int count_of(input logic [15:0] v);
    int c = 0;
    foreach (reqs[k]) if (reqs[k] == v) c++;
    return c;
  endfunction

  initial begin
    int r;
    tbl = '{16'h0280, 16'h0F12, 16'h1801};
    nk = '{0, 0, 0};
    RESET = 1;
    step();
    step();
    RESET = 0;
    chk_en = 1;
    chk("rst_idx", TBL_IDX, 0);
    chk("rst_reg", I2C_REG, 0);
    chk("rst_data", I2C_DATA, 0);
    chk("rst_erridx", ERR_IDX, 0);
    chk("rst_busy", BUSY, 0);
    // plain walk, fixed master latency
    lat_fix = 5;
    run(-1);
    step();
    chk("s1_nreq", reqs.size(), 3);
    chk("s1_w0", reqs[0], 16'h0280);
    chk("s1_w1", reqs[1], 16'h0F12);
    chk("s1_w2", reqs[2], 16'h1801);
    chk("s1_first", rises[0] - t_start, 12);
    chk("s1_hold", falls[0] - rises[0], 6);
    chk("s1_gap", rises[1] - falls[0], 6);
    chk("s1_done", DONE, 1);
    chk("s1_busy", BUSY, 0);
    // entry 1 NACKs twice
    nk = '{0, 2, 0};
    run(-1);
    step();
    chk("s2_nreq", reqs.size(), 5);
    chk("s2_e1", count_of(16'h0F12), 3);
    chk("s2_retry_gap", rises[2] - falls[1], 4);
    chk("s2_done", DONE, 1);
    // entry 2 always NACKs
    nk = '{0, 0, 4};
    run(-1);
    wait_n(30, 0);
    chk("s3_nreq", reqs.size(), 6);
    chk("s3_e2", count_of(16'h1801), 4);
    chk("s3_error", ERROR, 1);
    chk("s3_erridx", ERR_IDX, 2);
    chk("s3_done", DONE, 0);
    // restart from FAIL
    nk = '{0, 0, 0};
    run(-1);
    step();
    chk("s6_rerun_w0", reqs[0], 16'h0280);
    chk("s6_rerun_err", ERROR, 0);
    // delay entry
    tbl = '{16'h0280, 16'hFF03, 16'h0F12};
    run(-1);
    step();
    chk("s4_nreq", reqs.size(), 2);
    chk("s4_gap", rises[1] - falls[0], 32);
    chk("s4_done", DONE, 1);
    // reset mid-request on entry 1
    tbl = '{16'h0280, 16'h0F12, 16'h1801};
    run(1);
    chk("s5_req", I2C_REQ, 0);
    chk("s5_idx", TBL_IDX, 0);
    chk("s5_reg", I2C_REG, 0);
    chk("s5_data", I2C_DATA, 0);
    run(-1);
    step();
    chk("s5_nreq", reqs.size(), 3);
    chk("s5_done", DONE, 1);
    // spurious START / I2C_DONE while sequencing
    noise = 1;
    lat_fix = -1;
    run(-1);
    step();
    chk("s6_noise_done", DONE, 1);
    // randomized tables, NACK patterns, latencies and aborts
    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < N; k++) begin
        tbl[k] = $urandom_range(0, 3) == 0 ? {8'hFF, 8'($urandom_range(0, 4))}
                                           : {8'($urandom_range(0, 254)), 8'($urandom)};
        r = $urandom_range(0, 9);
        nk[k] = r < 6 ? 0 : r < 9 ? int'($urandom_range(1, 3)) : 4;
      end
      noise = 1'($urandom_range(0, 1));
      run($urandom_range(0, 7) == 0 ? int'($urandom_range(0, N - 1)) : -1);
      wait_n(3, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
